// File: rtl/pc_branch_unit_pkg.sv
// Shared definitions for the PC / branch-resolution stage: sequencer states,
// branch condition codes and the absolute branch-target table.
package pc_branch_unit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } pcb_state_t;

  localparam logic [1:0] kCOND_AL = 2'b00;
  localparam logic [1:0] kCOND_EQ = 2'b01;
  localparam logic [1:0] kCOND_LT = 2'b10;
  localparam logic [1:0] kCOND_NE = 2'b11;

  localparam int kLUT_DEPTH = 16;
  localparam int kLUT_AW    = 4;

  // Targets are stored 16 bits wide and cut down to the PC width at the read port.
  localparam logic [15:0] kBRANCH_TARGETS [kLUT_DEPTH] = '{
    16'd0,   16'd10,  16'd20,   16'd37,
    16'd100, 16'd512, 16'd1023, 16'd8,
    16'd0,   16'd0,   16'd0,    16'd0,
    16'd0,   16'd0,   16'd0,    16'd0
  };

  function automatic logic [15:0] lut_entry(input logic [31:0] idx);
    logic [15:0] val;
    if (idx < 32'(kLUT_DEPTH)) begin
      val = kBRANCH_TARGETS[idx[kLUT_AW-1:0]];
    end else begin
      val = 16'd0;
    end
    return val;
  endfunction

  function automatic logic cond_met(input logic [1:0] cond, input logic z, input logic n);
    logic res;
    case (cond)
      kCOND_AL: res = 1'b1;
      kCOND_EQ: res = z;
      kCOND_LT: res = n;
      kCOND_NE: res = ~z;
      default:  res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/pc_branch_unit_if.sv
// Decoder/ALU-facing bundle of the PC / branch unit; master drives the
// instruction controls, slave returns PC, flags and sequencer status.
interface pc_branch_unit_if #(
  parameter int PC_W      = 10,
  parameter int LUT_IDX_W = 4
);
  logic                 Start;
  logic                 Stall;
  logic                 FlagWe;
  logic                 ZeroIn;
  logic                 NegativeIn;
  logic                 Branch;
  logic [1:0]           BranchCond;
  logic [LUT_IDX_W-1:0] TargetIdx;
  logic                 Halt;
  logic [PC_W-1:0]      PC;
  logic                 FlagZ;
  logic                 FlagN;
  logic                 BranchTaken;
  logic                 Running;
  logic                 Done;

  modport master (
    output Start, Stall, FlagWe, ZeroIn, NegativeIn, Branch, BranchCond, TargetIdx, Halt,
    input  PC, FlagZ, FlagN, BranchTaken, Running, Done
  );

  modport slave (
    input  Start, Stall, FlagWe, ZeroIn, NegativeIn, Branch, BranchCond, TargetIdx, Halt,
    output PC, FlagZ, FlagN, BranchTaken, Running, Done
  );
endinterface

// File: rtl/pc_branch_unit_branch_lut.sv
// Combinational branch-target lookup: LUT index to absolute PC; entries
// beyond the table read as 0.
module branch_lut
  import pc_branch_unit_pkg::*;
#(
  parameter int PC_W      = 10,
  parameter int LUT_IDX_W = 4
) (
  input  logic [LUT_IDX_W-1:0] target_idx,
  output logic [PC_W-1:0]      target
);

  // Table read, resized to the PC width
  always_comb begin
    target = PC_W'(lut_entry(32'(target_idx)));
  end

endmodule

// File: rtl/pc_branch_unit.sv
// Program counter, flag register and branch resolution with an IDLE/RUN/DONE
// sequencer; every output is taken straight from a flop.
module pc_branch_unit
  import pc_branch_unit_pkg::*;
#(
  parameter int PC_W      = 10,
  parameter int LUT_IDX_W = 4
) (
  input logic               Clk,
  input logic               Reset_n,
  pc_branch_unit_if.slave   bus
);

  pcb_state_t      state_r;
  logic [PC_W-1:0] pc_r;
  logic [PC_W-1:0] pc_inc_s;
  logic [PC_W-1:0] target_s;
  logic            flag_z_r;
  logic            flag_n_r;
  logic            branch_taken_r;
  logic            running_r;
  logic            done_r;
  logic            take_s;

  branch_lut #(
    .PC_W      (PC_W),
    .LUT_IDX_W (LUT_IDX_W)
  ) u_branch_lut (
    .target_idx (bus.TargetIdx),
    .target     (target_s)
  );

  // Natural overflow gives the wrap from all-ones back to 0.
  assign pc_inc_s = pc_r + {{(PC_W-1){1'b0}}, 1'b1};
  // Conditions see the flags registered before this instruction (no forwarding).
  assign take_s   = bus.Branch & cond_met(bus.BranchCond, flag_z_r, flag_n_r);

  // Sequencer, PC, flags and status registers
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r        <= IDLE;
      pc_r           <= {PC_W{1'b0}};
      flag_z_r       <= 1'b0;
      flag_n_r       <= 1'b0;
      branch_taken_r <= 1'b0;
      running_r      <= 1'b0;
      done_r         <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          pc_r           <= {PC_W{1'b0}};
          branch_taken_r <= 1'b0;
          if (bus.Start) begin
            state_r   <= RUN;
            running_r <= 1'b1;
            done_r    <= 1'b0;
            flag_z_r  <= 1'b0;
            flag_n_r  <= 1'b0;
          end
        end
        RUN: begin
          if (bus.Stall) begin
            branch_taken_r <= 1'b0;
          end else begin
            if (bus.FlagWe) begin
              flag_z_r <= bus.ZeroIn;
              flag_n_r <= bus.NegativeIn;
            end
            if (bus.Halt) begin
              state_r        <= DONE;
              running_r      <= 1'b0;
              done_r         <= 1'b1;
              branch_taken_r <= 1'b0;
            end else if (take_s) begin
              pc_r           <= target_s;
              branch_taken_r <= 1'b1;
            end else begin
              pc_r           <= pc_inc_s;
              branch_taken_r <= 1'b0;
            end
          end
        end
        DONE: begin
          branch_taken_r <= 1'b0;
          if (bus.Start) begin
            state_r   <= RUN;
            pc_r      <= {PC_W{1'b0}};
            flag_z_r  <= 1'b0;
            flag_n_r  <= 1'b0;
            running_r <= 1'b1;
            done_r    <= 1'b0;
          end
        end
        default: begin
          state_r        <= IDLE;
          pc_r           <= {PC_W{1'b0}};
          flag_z_r       <= 1'b0;
          flag_n_r       <= 1'b0;
          branch_taken_r <= 1'b0;
          running_r      <= 1'b0;
          done_r         <= 1'b0;
        end
      endcase
    end
  end

  assign bus.PC          = pc_r;
  assign bus.FlagZ       = flag_z_r;
  assign bus.FlagN       = flag_n_r;
  assign bus.BranchTaken = branch_taken_r;
  assign bus.Running     = running_r;
  assign bus.Done        = done_r;

endmodule
